// File: rtl/trail_ram_arbiter.sv
// Single-port trail RAM arbiter. It grants display reads first, then buffered player
// writes in round-robin order, then scanner reads, and routes read data back by tag.
module trail_ram_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 3,
    parameter int RD_LAT = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [3:0]        wr_stb,
    input  logic [ADDR_W-1:0] p1,
    input  logic [ADDR_W-1:0] p2,
    input  logic [ADDR_W-1:0] p3,
    input  logic [ADDR_W-1:0] p4,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_gnt,
    output logic              scan_valid,
    output logic [DATA_W-1:0] scan_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q,
    output logic [3:0]        wr_pending,
    output logic [3:0]        overflow
);
    localparam logic [3:0][DATA_W-1:0] COLOUR = {DATA_W'(6), DATA_W'(4), DATA_W'(2), DATA_W'(1)};

    logic [3:0][ADDR_W-1:0] pos;
    logic [3:0][ADDR_W-1:0] buf_q, buf_d;
    logic [3:0]             pend_q, pend_d;
    logic [3:0]             ovf_q, ovf_d;
    logic [1:0]             rr_q, rr_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   wren_q, wren_d;
    // Tag bit 1 = display read, bit 0 = scanner read.
    logic [RD_LAT:0][1:0]   tag_q, tag_d;
    logic                   dv_q, dv_d, sv_q, sv_d;
    logic [DATA_W-1:0]      dd_q, dd_d, sd_q, sd_d;

    logic       rd_disp, rd_scan, wr_gnt, found;
    logic [1:0] wr_sel, idx;

    assign pos = {p4, p3, p2, p1};

    always_comb begin
        rd_disp = 1'b0;
        rd_scan = 1'b0;
        wr_gnt  = 1'b0;
        wr_sel  = rr_q;
        found   = 1'b0;
        idx     = 2'd0;
        if (disp_req) begin
            rd_disp = 1'b1;
        end else if (|pend_q) begin
            wr_gnt = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                idx = rr_q + 2'(k);
                if (!found && pend_q[idx]) begin
                    found  = 1'b1;
                    wr_sel = idx;
                end
            end
        end else if (scan_req) begin
            rd_scan = 1'b1;
        end
    end

    assign scan_gnt = scan_req & ~disp_req & ~|pend_q;

    always_comb begin
        buf_d   = buf_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wren_d  = 1'b0;
        if (rd_disp) addr_d = disp_addr;
        if (rd_scan) addr_d = scan_addr;
        if (wr_gnt) begin
            addr_d         = buf_q[wr_sel];
            wdata_d        = COLOUR[wr_sel];
            wren_d         = 1'b1;
            pend_d[wr_sel] = 1'b0;
            rr_d           = wr_sel;
        end
        // A strobe landing on the cycle its entry drains refills the buffer cleanly.
        for (int i = 0; i < 4; i++) begin
            if (wr_stb[i]) begin
                if (!pend_q[i] || (wr_gnt && wr_sel == 2'(i))) begin
                    buf_d[i]  = pos[i];
                    pend_d[i] = 1'b1;
                end else begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
        tag_d = {tag_q[RD_LAT-1:0], {rd_disp, rd_scan}};
        dv_d  = tag_q[RD_LAT][1];
        sv_d  = tag_q[RD_LAT][0];
        dd_d  = tag_q[RD_LAT][1] ? ram_q : dd_q;
        sd_d  = tag_q[RD_LAT][0] ? ram_q : sd_q;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            buf_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
            rr_q    <= 2'd3;
            addr_q  <= '0;
            wdata_q <= '0;
            wren_q  <= 1'b0;
            tag_q   <= '0;
            dv_q    <= 1'b0;
            sv_q    <= 1'b0;
            dd_q    <= '0;
            sd_q    <= '0;
        end else begin
            buf_q   <= buf_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wren_q  <= wren_d;
            tag_q   <= tag_d;
            dv_q    <= dv_d;
            sv_q    <= sv_d;
            dd_q    <= dd_d;
            sd_q    <= sd_d;
        end
    end

    assign ram_address = addr_q;
    assign ram_wren    = wren_q;
    assign ram_data    = wdata_q;
    assign wr_pending  = pend_q;
    assign overflow    = ovf_q;
    assign disp_valid  = dv_q;
    assign disp_data   = dd_q;
    assign scan_valid  = sv_q;
    assign scan_data   = sd_q;
endmodule

// File: tb/tb_trail_ram_arbiter.sv
// Bench for trail_ram_arbiter: a RAM model, a cycle-numbered reference model with a
// scoreboard of pending read returns, and directed scenarios with literal expectations.
module tb_trail_ram_arbiter;
    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  wr_stb = '0;
    logic [14:0] p1 = '0, p2 = '0, p3 = '0, p4 = '0;
    logic        disp_req = 1'b0, scan_req = 1'b0;
    logic [14:0] disp_addr = '0, scan_addr = '0;
    logic        disp_valid, scan_valid, scan_gnt, ram_wren;
    logic [2:0]  disp_data, scan_data, ram_data, ram_q;
    logic [14:0] ram_address;
    logic [3:0]  wr_pending, overflow;

    int n_vec = 0, n_err = 0;
    bit run = 1'b1;

    trail_ram_arbiter #(.ADDR_W(15), .DATA_W(3), .RD_LAT(RD_LAT)) dut (
        .CLOCK_50(clk), .reset(reset), .wr_stb(wr_stb),
        .p1(p1), .p2(p2), .p3(p3), .p4(p4),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(scan_gnt),
        .scan_valid(scan_valid), .scan_data(scan_data),
        .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data),
        .ram_q(ram_q), .wr_pending(wr_pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // RAM model: registered read with RD_LAT cycles from the registered address.
    logic [2:0] mem [0:32767];
    logic [2:0] qp  [0:RD_LAT-1];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        qp[0] <= mem[ram_address];
        for (int i = 1; i < RD_LAT; i++) qp[i] <= qp[i-1];
    end
    assign ram_q = qp[RD_LAT-1];

    // Reference model: which operation happens on each edge, and when each read returns.
    typedef struct { int due; bit is_disp; logic [2:0] d; } ret_t;
    ret_t        rq[$];
    logic [2:0]  m_mem [0:32767];
    logic [14:0] m_buf [4];
    bit   [3:0]  m_pend, m_ovf;
    int          m_last, cyc;
    logic [14:0] e_addr;
    logic [2:0]  e_wdata, e_dd, e_sd;
    bit          e_wren, e_dv, e_sv;

    function automatic logic [14:0] player_pos(int i);
        case (i)
            0: return p1;
            1: return p2;
            2: return p3;
            default: return p4;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rq.delete();
            m_pend = '0; m_ovf = '0; m_last = 3;
            e_addr = '0; e_wdata = '0; e_wren = 0;
            e_dv = 0; e_sv = 0; e_dd = '0; e_sd = '0;
        end else begin
            int g;
            ret_t r;
            cyc++;
            e_dv = 0; e_sv = 0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                if (r.is_disp) begin e_dv = 1; e_dd = r.d; end
                else           begin e_sv = 1; e_sd = r.d; end
            end
            g = -1;
            e_wren = 0;
            if (disp_req) begin
                rq.push_back('{cyc + RD_LAT + 1, 1'b1, m_mem[disp_addr]});
                e_addr = disp_addr;
            end else if (m_pend != 0) begin
                for (int k = 1; k <= 4 && g < 0; k++)
                    if (m_pend[(m_last + k) % 4]) g = (m_last + k) % 4;
                e_addr = m_buf[g]; e_wdata = 3'((g == 3) ? 6 : (1 << g)); e_wren = 1;
                m_mem[m_buf[g]] = e_wdata;
                m_pend[g] = 0; m_last = g;
            end else if (scan_req) begin
                rq.push_back('{cyc + RD_LAT + 1, 1'b0, m_mem[scan_addr]});
                e_addr = scan_addr;
            end
            for (int i = 0; i < 4; i++)
                if (wr_stb[i]) begin
                    if (m_pend[i]) m_ovf[i] = 1;
                    else begin m_buf[i] = player_pos(i); m_pend[i] = 1; end
                end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (run) begin
            chk("m_ram_address", 32'(ram_address), 32'(e_addr));
            chk("m_ram_wren", 32'(ram_wren), 32'(e_wren));
            chk("m_ram_data", 32'(ram_data), 32'(e_wdata));
            chk("m_wr_pending", 32'(wr_pending), 32'(m_pend));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
            chk("m_disp_valid", 32'(disp_valid), 32'(e_dv));
            chk("m_disp_data", 32'(disp_data), 32'(e_dd));
            chk("m_scan_valid", 32'(scan_valid), 32'(e_sv));
            chk("m_scan_data", 32'(scan_data), 32'(e_sd));
        end
    end

    always @(negedge clk)
        if (run) chk("m_scan_gnt", 32'(scan_gnt), 32'(scan_req && !disp_req && m_pend == 0 && !reset));

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_addr"}, 32'(ram_address), 0);
        chk({tag, "_wren"}, 32'(ram_wren), 0);
        chk({tag, "_data"}, 32'(ram_data), 0);
        chk({tag, "_vld"}, {30'd0, disp_valid, scan_valid}, 0);
        chk({tag, "_pend"}, 32'(wr_pending), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
    endtask

    initial begin
        logic [14:0] wa [4];
        logic [2:0]  sd [4];
        wa[0] = 15'h4EF6; wa[1] = 15'h0082; wa[2] = 15'h4E82; wa[3] = 15'h00F6;
        sd[0] = 3'd5; sd[1] = 3'd6; sd[2] = 3'd7; sd[3] = 3'd1;
        for (int a = 0; a < 32768; a++) begin mem[a] = '0; m_mem[a] = '0; end
        mem[5] = 3'b010; m_mem[5] = 3'b010;
        for (int a = 0; a < 4; a++) begin mem[a] = sd[a]; m_mem[a] = sd[a]; end
        qp[0] = '0;
        cyc = 0;

        // Reset, then one display read of address 5.
        tick(); tick();
        all_zero("rst");
        reset = 1'b0;
        disp_req = 1'b1; disp_addr = 15'h0005;
        tick();
        chk("rd_addr", 32'(ram_address), 32'h5);
        chk("rd_wren", 32'(ram_wren), 0);
        disp_req = 1'b0;
        tick();
        chk("rd_early", 32'(disp_valid), 0);
        tick();
        chk("rd_valid", 32'(disp_valid), 1);
        chk("rd_data", 32'(disp_data), 32'b010);
        chk("rd_scan_vld", 32'(scan_valid), 0);
        tick();
        chk("rd_done", 32'(disp_valid), 0);

        // All four players strobe together.
        p1 = wa[0]; p2 = wa[1]; p3 = wa[2]; p4 = wa[3]; wr_stb = 4'b1111;
        tick();
        wr_stb = '0;
        chk("wr4_pend0", 32'(wr_pending), 32'b1111);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("wr4_wren", 32'(ram_wren), 1);
            chk("wr4_addr", 32'(ram_address), 32'(wa[k]));
            chk("wr4_col", 32'(ram_data), (k == 3) ? 32'd6 : (32'd1 << k));
            chk("wr4_pend", 32'(wr_pending), 32'((4'b1111 << (k + 1)) & 4'hF));
        end

        // Display hogs the port; the player 2 write waits for the first gap.
        p2 = 15'h0123;
        for (int c = 1; c <= 10; c++) begin
            disp_req = 1'b1; disp_addr = 15'(c);
            wr_stb = (c == 2) ? 4'b0010 : 4'b0000;
            tick();
            chk("hog_nowr", 32'(ram_wren), 0);
        end
        disp_req = 1'b0; wr_stb = '0;
        tick();
        chk("hog_wr", 32'(ram_wren), 1);
        chk("hog_addr", 32'(ram_address), 32'h0123);
        chk("hog_col", 32'(ram_data), 32'b010);
        chk("hog_ovf", 32'(overflow), 0);

        // Blocked second strobe overflows; a strobe on the grant cycle does not.
        disp_req = 1'b1; disp_addr = 15'h0007;
        p1 = 15'h1111; wr_stb = 4'b0001; tick();
        p1 = 15'h2222; tick();
        wr_stb = '0;
        chk("ovf_set", 32'(overflow), 32'b0001);
        disp_req = 1'b0;
        tick();
        chk("ovf_first", 32'(ram_address), 32'h1111);
        chk("ovf_wren", 32'(ram_wren), 1);
        p1 = 15'h3333; wr_stb = 4'b0001; tick();
        p1 = 15'h4444; tick();
        wr_stb = '0;
        chk("coin_addr", 32'(ram_address), 32'h3333);
        chk("coin_pend", 32'(wr_pending), 32'b0001);
        chk("coin_ovf", 32'(overflow), 32'b0001);
        tick();
        chk("coin_second", 32'(ram_address), 32'h4444);
        chk("coin_wren", 32'(ram_wren), 1);
        tick();

        // Scanner reads addresses 0..3 back to back.
        scan_req = 1'b1; scan_addr = 15'd0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk); #1;
            if (j < 4) chk("scan_gnt", 32'(scan_gnt), 1);
            tick();
            if (j >= 2) begin
                chk("scan_vld", 32'(scan_valid), 1);
                chk("scan_dat", 32'(scan_data), 32'(sd[j-2]));
            end else begin
                chk("scan_lat", 32'(scan_valid), 0);
            end
            if (j < 3) scan_addr = 15'(j + 1);
            else scan_req = 1'b0;
        end

        // A pending write holds the scanner off for one cycle.
        scan_req = 1'b1; scan_addr = 15'd8; p3 = 15'h0300; wr_stb = 4'b0100;
        @(negedge clk); #1;
        chk("sup_gnt0", 32'(scan_gnt), 1);
        tick();
        wr_stb = '0; scan_addr = 15'd9;
        @(negedge clk); #1;
        chk("sup_gnt1", 32'(scan_gnt), 0);
        tick();
        chk("sup_wr", 32'(ram_address), 32'h0300);
        chk("sup_col", 32'(ram_data), 32'b100);
        @(negedge clk); #1;
        chk("sup_gnt2", 32'(scan_gnt), 1);
        tick();
        scan_req = 1'b0;
        tick(); tick(); tick();

        // Reset lands while a display read is in flight.
        disp_req = 1'b1; disp_addr = 15'h0005;
        tick();
        disp_req = 1'b0; reset = 1'b1;
        #1;
        all_zero("rst2");
        tick();
        all_zero("rst2b");
        tick();
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("rst2_novld", 32'(disp_valid), 0);
        end

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1);
    end
endmodule

// File: doc/trail_ram_arbiter.md
# trail_ram_arbiter

Single-port arbiter for the 160x120 trail RAM (15-bit address {x[7:0], y[6:0]}, 3-bit colour). It shares one RAM port among three requesters, issuing at most one RAM operation per cycle:
- the four player trail writers, driven from the player positions;
- the VGA display reader;
- the end-of-game score scanner.

It replaces the ad-hoc write/read sequencing with fixed priority, per-player write buffering and read-data return routing.

## Interface
Parameters:
- ADDR_W, 15, RAM address width
- DATA_W, 3, RAM word width
- RD_LAT, 1, RAM read latency in cycles from registered address to valid ram_q (1..4)

Ports:
- CLOCK_50  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wr_stb  in  4  per-player write strobe, bit i = player i+1, one-cycle pulse per move
- p1, p2, p3, p4  in  ADDR_W each  player positions, sampled on the matching wr_stb bit
- disp_req  in  1  display read request, may be high every cycle
- disp_addr  in  ADDR_W  display read address
- disp_valid  out  1  display read data valid
- disp_data  out  DATA_W  display read data
- scan_req  in  1  scanner read request, held until granted
- scan_addr  in  ADDR_W  scanner address, held until granted
- scan_gnt  out  1  combinational; scanner request accepted this cycle
- scan_valid  out  1  scanner read data valid
- scan_data  out  DATA_W  scanner read data
- ram_address  out  ADDR_W  registered RAM address
- ram_wren  out  1  registered RAM write enable
- ram_data  out  DATA_W  registered RAM write data
- ram_q  in  DATA_W  RAM read data
- wr_pending  out  4  per-player write buffer occupied
- overflow  out  4  sticky; a strobe was dropped for that player

## Operation
- Write buffer: one entry per player (address plus implicit colour). Fixed colours: p1=001, p2=010, p3=100, p4=110.
- Strobe with buffer empty: load the buffer and set wr_pending[i].
- Strobe with buffer full and not granted this cycle: drop the new strobe, keep the old entry, set overflow[i].
- Strobe in the same cycle the buffer is granted: the old entry issues, the new entry loads, and no overflow is flagged.
- Priority per cycle, decided from current inputs:
  - first, disp_req (always accepted);
  - else, any pending write, chosen round-robin;
  - else, scan_req.
- Round-robin pointer: search starts at the player after the last granted one. The pointer updates only on a write grant. Reset value 3, so player 1 is first.
- scan_gnt = scan_req & ~disp_req & ~|wr_pending. The scanner advances its address on the edge where scan_gnt is high.
- Issue on the edge:
  - Read: ram_address ← request address, ram_wren ← 0.
  - Write: ram_address ← player address, ram_data ← player colour, ram_wren ← 1, and the buffer clears.
  - Idle: ram_wren ← 0; ram_address and ram_data hold.
- Return routing: a tag pipeline RD_LAT+1 stages deep carries {is_disp, is_scan}. At the tail, the tag selects which of disp_valid/disp_data or scan_valid/scan_data registers ram_q. The other valid stays 0.
- Display starvation of writes and scan is permitted by design; the display controller leaves blanking gaps.
- Overflow clears only on reset.

## Timing
- Read latency: request sampled at edge N; ram_address valid after edge N; data/valid registered at edge N+RD_LAT+1. With RD_LAT=1 that is 2 cycles, and the pipeline sustains one read per cycle.
- Write: strobe at edge N loads the buffer. Earliest issue is at edge N+1, with ram_wren high during the cycle after N+1.
- A write and a read never issue in the same cycle.
- Reset values:
  - all outputs 0, including ram_address, ram_data, ram_wren, valids, wr_pending and overflow;
  - round-robin pointer 3;
  - tag pipeline cleared.
- Reset mid-read: in-flight tags are discarded, so no valid is asserted after reset deasserts for reads issued before it.
- Simultaneous strobes on all four players: all load, then issue p1, p2, p3, p4 on consecutive free cycles.

## Test plan
- Reset, then disp_req=1 with disp_addr=0x0005 and ram_q model returning 3'b010 → disp_valid=1, disp_data=010 exactly 2 cycles after sampling. Idle outputs stay 0.
- wr_stb=4'b1111, p1=0x4EF6, p2=0x0082, p3=0x4E82, p4=0x00F6, no reads → 4 consecutive writes in order p1..p4 with colours 001/010/100/110. wr_pending goes 1111→1110→1100→1000→0000.
- disp_req held high for 10 cycles with a player 2 strobe at cycle 2 → no write during cycles 2..10. The p2 write issues in the first cycle disp_req is low; overflow stays 0.
- Second player 1 strobe while its buffer is blocked by disp_req → overflow=0001 and the first address is written. A strobe coinciding with a grant → no overflow, both addresses written.
- scan_req with addresses 0..3 and no other traffic → scan_gnt high 4 consecutive cycles, scan_valid for 4 cycles, data in order. A pending write suppresses scan_gnt for one cycle.
- Assert reset one cycle after a display read issues → disp_valid never pulses, and all outputs read 0 during reset.
